// File: rtl/debounce_array.sv
// Per-channel key debouncer with symmetric press/release filtering, edge pulses
// and a one-shot long-press pulse. Channels are independent replicas of debounce_chan.

module debounce_chan #(
    parameter int CW     = 20,
    parameter int THRESH = 2**CW - 1,
    parameter int LW     = 24,
    parameter int LONG   = 2**LW - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic nse,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic lng
);

    localparam logic [CW-1:0] THR_M1    = CW'(THRESH - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG);
    localparam logic [LW-1:0] LONG_M1   = LW'(LONG - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic [LW-1:0] hc_q, hc_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          lng_q, lng_d;
    logic          accept;

    // Stability counter: any return of s2 to the current level restarts the interval.
    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        accept = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == THR_M1) begin
            cnt_d  = '0;
            lvl_d  = ~lvl_q;
            accept = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        rise_d = accept & ~lvl_q;
        fall_d = accept & lvl_q;
    end

    // Hold counter saturates at LONG, so lng fires once per press; a release
    // accepted on the same edge wins over the long-press pulse.
    always_comb begin
        hc_d  = hc_q;
        lng_d = 1'b0;
        if (!lvl_q) begin
            hc_d = '0;
        end else if (hc_q != LONG_MAX) begin
            hc_d  = hc_q + 1'b1;
            lng_d = (hc_q == LONG_M1) & ~accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            hc_q   <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            lng_q  <= 1'b0;
        end else begin
            s1_q   <= nse;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            hc_q   <= hc_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            lng_q  <= lng_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign lng  = lng_q;

endmodule

module debounce_array #(
    parameter int NCH    = 4,
    parameter int CW     = 20,
    parameter int THRESH = 2**CW - 1,
    parameter int LW     = 24,
    parameter int LONG   = 2**LW - 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] nse,
    output logic [NCH-1:0] lvl,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] lng
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_chan #(
            .CW    (CW),
            .THRESH(THRESH),
            .LW    (LW),
            .LONG  (LONG)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .nse (nse[i]),
            .lvl (lvl[i]),
            .rise(rise[i]),
            .fall(fall[i]),
            .lng (lng[i])
        );
    end

endmodule
